// File: rtl/pose_error.sv
`default_nettype none
//==============================================================================
// Module   : pose_error
// Brief    : Dead-reckoning pose tracker. Integrates commanded body velocities
//            once per tick into an (X, Y, theta) pose estimate and publishes the
//            registered error (target - pose) in sign-magnitude form. Stops
//            integrating once the controller reports the goal on two
//            consecutive ticks.
// Revision : 1.0 - initial release
//==============================================================================
module pose_error #(
    parameter int N_WIDTH  = 17,
    parameter int TICK_DIV = 390625,
    parameter int RAD2DEG  = 57,
    parameter int ACC_W    = 26
) (
    input  logic               POSE_ERROR_CLOCK_50,
    input  logic               POSE_ERROR_RESET_InHigh,
    input  logic               POSE_ERROR_TARGET_LOAD_In,
    input  logic [N_WIDTH-1:0] POSE_ERROR_TARGET_X_InBus,
    input  logic [N_WIDTH-1:0] POSE_ERROR_TARGET_Y_InBus,
    input  logic [N_WIDTH-1:0] POSE_ERROR_TARGET_Z_InBus,
    input  logic [N_WIDTH-1:0] POSE_ERROR_VX_InBus,
    input  logic [N_WIDTH-1:0] POSE_ERROR_VY_InBus,
    input  logic [N_WIDTH-1:0] POSE_ERROR_WZ_InBus,
    input  logic               POSE_ERROR_GOAL_FLAG_InLow,
    output logic [N_WIDTH-1:0] POSE_ERROR_X_OutBus,
    output logic [N_WIDTH-1:0] POSE_ERROR_Y_OutBus,
    output logic [N_WIDTH-1:0] POSE_ERROR_Z_OutBus,
    output logic               POSE_ERROR_VALID_Out,
    output logic               POSE_ERROR_DONE_Out
);

    // Bus values carry 8 fraction bits, accumulators carry 15; with dt = 1/128 s
    // a bus velocity read as an accumulator value is exactly v*dt.
    localparam int c_BUS_FRAC = 8;
    localparam int c_ACC_FRAC = 15;
    localparam int c_SHIFT    = c_ACC_FRAC - c_BUS_FRAC;
    localparam int c_MAG_W    = N_WIDTH - 1;
    localparam int c_TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [c_TICK_W-1:0]    c_TICK_LAST = c_TICK_W'(TICK_DIV - 1);
    localparam logic [ACC_W-1:0]       c_MAG_MAX   = ACC_W'(2**c_MAG_W - 1);
    localparam logic [ACC_W-1:0]       c_RAD2DEG   = ACC_W'(RAD2DEG);
    localparam logic signed [ACC_W-1:0] c_XY_LIM   = ACC_W'((2**c_MAG_W - 1) * (2**c_SHIFT));
    localparam logic signed [ACC_W-1:0] c_DEG180   = ACC_W'(180 * (2**c_ACC_FRAC));
    localparam logic signed [ACC_W-1:0] c_DEG360   = ACC_W'(360 * (2**c_ACC_FRAC));

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_TRACK = 2'd1;
    localparam logic [1:0] c_ST_DONE  = 2'd2;

    // Sign-magnitude to two's complement; negative zero collapses to zero.
    function automatic logic signed [N_WIDTH-1:0] sm_to_tc(input logic [N_WIDTH-1:0] sm);
        logic [N_WIDTH-1:0] mag;
        mag = {1'b0, sm[N_WIDTH-2:0]};
        return sm[N_WIDTH-1] ? -mag : mag;
    endfunction

    // Sign-extend a bus-resolution value into accumulator width (same LSB weight).
    function automatic logic signed [ACC_W-1:0] ext_raw(input logic signed [N_WIDTH-1:0] v);
        return {{(ACC_W-N_WIDTH){v[N_WIDTH-1]}}, v};
    endfunction

    // Re-scale a bus-resolution value to accumulator resolution (8 -> 15 fraction bits).
    function automatic logic signed [ACC_W-1:0] bus_to_acc(input logic signed [N_WIDTH-1:0] v);
        return {{(ACC_W-N_WIDTH-c_SHIFT){v[N_WIDTH-1]}}, v, {c_SHIFT{1'b0}}};
    endfunction

    // Clamp a linear position to the largest magnitude the bus can express.
    function automatic logic signed [ACC_W-1:0] sat_xy(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] r;
        r = v;
        if (v > c_XY_LIM) begin
            r = c_XY_LIM;
        end else if (v < -c_XY_LIM) begin
            r = -c_XY_LIM;
        end
        return r;
    endfunction

    // Fold an angle into (-180, 180]; inputs never stray more than one turn out.
    function automatic logic signed [ACC_W-1:0] wrap_deg(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] r;
        r = v;
        if (v > c_DEG180) begin
            r = v - c_DEG360;
        end else if (v <= -c_DEG180) begin
            r = v + c_DEG360;
        end
        return r;
    endfunction

    // Accumulator to bus sign-magnitude: truncate toward zero, saturate the
    // magnitude, and never emit a negative zero.
    function automatic logic [N_WIDTH-1:0] acc_to_sm(input logic signed [ACC_W-1:0] v);
        logic [ACC_W-1:0]   mag;
        logic [ACC_W-1:0]   bus_mag;
        logic [c_MAG_W-1:0] m;
        mag     = v[ACC_W-1] ? -v : v;
        bus_mag = mag >> c_SHIFT;
        m       = (bus_mag > c_MAG_MAX) ? c_MAG_MAX[c_MAG_W-1:0] : bus_mag[c_MAG_W-1:0];
        return {(v[ACC_W-1] && (m != '0)), m};
    endfunction

    logic [1:0]                r_state;
    logic [1:0]                w_state_nxt;
    logic                      r_goal_seen;
    logic                      w_goal_seen_nxt;
    logic [c_TICK_W-1:0]       r_tick_cnt;
    logic                      w_tick;
    logic                      w_integrate;

    logic signed [N_WIDTH-1:0] r_tgt_x;
    logic signed [N_WIDTH-1:0] r_tgt_y;
    logic signed [N_WIDTH-1:0] r_tgt_z;
    logic signed [ACC_W-1:0]   r_pose_x;
    logic signed [ACC_W-1:0]   r_pose_y;
    logic signed [ACC_W-1:0]   r_theta;

    logic signed [N_WIDTH-1:0] w_vx_tc;
    logic signed [N_WIDTH-1:0] w_vy_tc;
    logic [ACC_W-1:0]          w_wz_prod;
    logic [ACC_W-1:0]          w_dth_mag;
    logic signed [ACC_W-1:0]   w_dth;
    logic signed [ACC_W-1:0]   w_pose_x_nxt;
    logic signed [ACC_W-1:0]   w_pose_y_nxt;
    logic signed [ACC_W-1:0]   w_theta_nxt;

    logic signed [ACC_W-1:0]   w_err_x_acc;
    logic signed [ACC_W-1:0]   w_err_y_acc;
    logic signed [ACC_W-1:0]   w_err_z_acc;

    logic                      r_int_d;
    logic                      r_valid;
    logic                      r_done;
    logic [N_WIDTH-1:0]        r_err_x;
    logic [N_WIDTH-1:0]        r_err_y;
    logic [N_WIDTH-1:0]        r_err_z;

    assign w_tick      = (r_tick_cnt == c_TICK_LAST);
    // A tick landing on the load cycle still integrates, whatever the state.
    assign w_integrate = w_tick && ((r_state == c_ST_TRACK) || POSE_ERROR_TARGET_LOAD_In);

    // Linear velocities are already v*dt at accumulator resolution.
    assign w_vx_tc = sm_to_tc(POSE_ERROR_VX_InBus);
    assign w_vy_tc = sm_to_tc(POSE_ERROR_VY_InBus);

    // Angle step: |wz_raw|*RAD2DEG/128 truncated to bus resolution, then sign applied,
    // so rounding is toward zero for both directions.
    assign w_wz_prod = {{(ACC_W-c_MAG_W){1'b0}}, POSE_ERROR_WZ_InBus[c_MAG_W-1:0]} * c_RAD2DEG;
    assign w_dth_mag = (w_wz_prod >> c_SHIFT) << c_SHIFT;
    assign w_dth     = POSE_ERROR_WZ_InBus[N_WIDTH-1] ? -$signed(w_dth_mag) : $signed(w_dth_mag);

    // Forward motion (VX) advances Y, lateral motion (VY) moves toward -X.
    assign w_pose_y_nxt = sat_xy(r_pose_y + ext_raw(w_vx_tc));
    assign w_pose_x_nxt = sat_xy(r_pose_x - ext_raw(w_vy_tc));
    assign w_theta_nxt  = wrap_deg(r_theta + w_dth);

    // Error terms are formed from the pose written on the previous edge.
    assign w_err_x_acc = bus_to_acc(r_tgt_x) - r_pose_x;
    assign w_err_y_acc = bus_to_acc(r_tgt_y) - r_pose_y;
    assign w_err_z_acc = wrap_deg(bus_to_acc(r_tgt_z) - r_theta);

    // Free-running tick divider, active in every state.
    always_ff @(posedge POSE_ERROR_CLOCK_50) begin
        if (POSE_ERROR_RESET_InHigh) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + c_TICK_W'(1);
        end
    end

    // State and goal-tick history registers.
    always_ff @(posedge POSE_ERROR_CLOCK_50) begin
        if (POSE_ERROR_RESET_InHigh) begin
            r_state     <= c_ST_IDLE;
            r_goal_seen <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_goal_seen <= w_goal_seen_nxt;
        end
    end

    // Next state: load always (re)enters TRACK; goal needs two consecutive low ticks.
    always_comb begin
        w_state_nxt     = r_state;
        w_goal_seen_nxt = r_goal_seen;
        case (r_state)
            c_ST_IDLE: begin
                if (POSE_ERROR_TARGET_LOAD_In) begin
                    w_state_nxt     = c_ST_TRACK;
                    w_goal_seen_nxt = 1'b0;
                end
            end
            c_ST_TRACK: begin
                if (POSE_ERROR_TARGET_LOAD_In) begin
                    w_goal_seen_nxt = 1'b0;
                end else if (w_tick) begin
                    if (!POSE_ERROR_GOAL_FLAG_InLow) begin
                        if (r_goal_seen) begin
                            w_state_nxt     = c_ST_DONE;
                            w_goal_seen_nxt = 1'b0;
                        end else begin
                            w_goal_seen_nxt = 1'b1;
                        end
                    end else begin
                        w_goal_seen_nxt = 1'b0;
                    end
                end
            end
            c_ST_DONE: begin
                if (POSE_ERROR_TARGET_LOAD_In) begin
                    w_state_nxt     = c_ST_TRACK;
                    w_goal_seen_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt     = c_ST_IDLE;
                w_goal_seen_nxt = 1'b0;
            end
        endcase
    end

    // Target capture on load and pose integration on qualifying ticks.
    always_ff @(posedge POSE_ERROR_CLOCK_50) begin
        if (POSE_ERROR_RESET_InHigh) begin
            r_tgt_x  <= '0;
            r_tgt_y  <= '0;
            r_tgt_z  <= '0;
            r_pose_x <= '0;
            r_pose_y <= '0;
            r_theta  <= '0;
        end else begin
            if (POSE_ERROR_TARGET_LOAD_In) begin
                r_tgt_x <= sm_to_tc(POSE_ERROR_TARGET_X_InBus);
                r_tgt_y <= sm_to_tc(POSE_ERROR_TARGET_Y_InBus);
                r_tgt_z <= sm_to_tc(POSE_ERROR_TARGET_Z_InBus);
            end
            if (w_integrate) begin
                r_pose_x <= w_pose_x_nxt;
                r_pose_y <= w_pose_y_nxt;
                r_theta  <= w_theta_nxt;
            end
        end
    end

    // Error publication two cycles after the tick, with a one-cycle valid strobe.
    always_ff @(posedge POSE_ERROR_CLOCK_50) begin
        if (POSE_ERROR_RESET_InHigh) begin
            r_int_d <= 1'b0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_err_x <= '0;
            r_err_y <= '0;
            r_err_z <= '0;
        end else begin
            r_int_d <= w_integrate;
            r_valid <= r_int_d;
            r_done  <= (w_state_nxt == c_ST_DONE);
            if (r_int_d) begin
                r_err_x <= acc_to_sm(w_err_x_acc);
                r_err_y <= acc_to_sm(w_err_y_acc);
                r_err_z <= acc_to_sm(w_err_z_acc);
            end
        end
    end

    assign POSE_ERROR_X_OutBus  = r_err_x;
    assign POSE_ERROR_Y_OutBus  = r_err_y;
    assign POSE_ERROR_Z_OutBus  = r_err_z;
    assign POSE_ERROR_VALID_Out = r_valid;
    assign POSE_ERROR_DONE_Out  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_pose_error.sv
`default_nettype none
//==============================================================================
// Module   : tb_pose_error
// Brief    : Directed vector bench for pose_error (short tick divider).
// Revision : 1.0 - initial release
//==============================================================================
module tb_pose_error;

    localparam int TD = 8;

    typedef struct {
        logic [16:0] tx;
        logic [16:0] ty;
        logic [16:0] tz;
        logic [16:0] vx;
        logic [16:0] vy;
        logic [16:0] wz;
        logic [16:0] ex;
        logic [16:0] ey;
        logic [16:0] ez;
    } vec_t;

    logic        clk    = 1'b0;
    logic        rst    = 1'b1;
    logic        load   = 1'b0;
    logic [16:0] tx     = '0;
    logic [16:0] ty     = '0;
    logic [16:0] tz     = '0;
    logic [16:0] vx     = '0;
    logic [16:0] vy     = '0;
    logic [16:0] wz     = '0;
    logic        goal_n = 1'b1;
    logic [16:0] ox;
    logic [16:0] oy;
    logic [16:0] oz;
    logic        valid;
    logic        done;

    int checks    = 0;
    int errors    = 0;
    int cyc       = 0;
    int mcnt      = 0;
    int last_tick = -100;

    vec_t vecs [13];

    pose_error #(
        .N_WIDTH (17),
        .TICK_DIV(TD),
        .RAD2DEG (57),
        .ACC_W   (26)
    ) dut (
        .POSE_ERROR_CLOCK_50       (clk),
        .POSE_ERROR_RESET_InHigh   (rst),
        .POSE_ERROR_TARGET_LOAD_In (load),
        .POSE_ERROR_TARGET_X_InBus (tx),
        .POSE_ERROR_TARGET_Y_InBus (ty),
        .POSE_ERROR_TARGET_Z_InBus (tz),
        .POSE_ERROR_VX_InBus       (vx),
        .POSE_ERROR_VY_InBus       (vy),
        .POSE_ERROR_WZ_InBus       (wz),
        .POSE_ERROR_GOAL_FLAG_InLow(goal_n),
        .POSE_ERROR_X_OutBus       (ox),
        .POSE_ERROR_Y_OutBus       (oy),
        .POSE_ERROR_Z_OutBus       (oz),
        .POSE_ERROR_VALID_Out      (valid),
        .POSE_ERROR_DONE_Out       (done)
    );

    always #5 clk = ~clk;

    // Cycle counter and reference tick position.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && mcnt == TD - 1) last_tick <= cyc;
        if (rst || mcnt == TD - 1) mcnt <= 0;
        else mcnt <= mcnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic [16:0] a_tx, a_ty, a_tz, a_vx, a_vy, a_wz,
                                input logic [16:0] a_ex, a_ey, a_ez);
        vec_t v;
        v.tx = a_tx; v.ty = a_ty; v.tz = a_tz;
        v.vx = a_vx; v.vy = a_vy; v.wz = a_wz;
        v.ex = a_ex; v.ey = a_ey; v.ez = a_ez;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        load = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic pulse_load();
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic wait_valid(output bit seen);
        seen = 1'b0;
        for (int k = 0; k < 4 * TD; k++) begin
            if (valid) begin
                seen = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic to_tick();
        for (int k = 0; k < TD + 1; k++) begin
            if (mcnt == TD - 1) break;
            step();
        end
    endtask

    initial begin
        bit seen;
        int nv;

        //            tx        ty        tz        vx        vy        wz        ex        ey        ez
        vecs[0]  = mk(17'h00000, 17'h00A00, 17'h00000, 17'h03200, 17'h00000, 17'h00000, 17'h00000, 17'h0099C, 17'h00000);
        vecs[1]  = mk(17'h00000, 17'h00000, 17'h00000, 17'h00000, 17'h13200, 17'h00000, 17'h10064, 17'h00000, 17'h00000);
        vecs[2]  = mk(17'h00000, 17'h00000, 17'h0B300, 17'h00000, 17'h00000, 17'h10300, 17'h00000, 17'h00000, 17'h1B3AA);
        vecs[3]  = mk(17'h00000, 17'h00000, 17'h00000, 17'h00000, 17'h00000, 17'h00300, 17'h00000, 17'h00000, 17'h10156);
        vecs[4]  = mk(17'h10000, 17'h10000, 17'h10000, 17'h10000, 17'h10000, 17'h10000, 17'h00000, 17'h00000, 17'h00000);
        vecs[5]  = mk(17'h1FFFF, 17'h00000, 17'h00000, 17'h00000, 17'h10100, 17'h00000, 17'h1FFFF, 17'h00000, 17'h00000);
        vecs[6]  = mk(17'h00000, 17'h00000, 17'h00000, 17'h00001, 17'h00000, 17'h00000, 17'h00000, 17'h00000, 17'h00000);
        vecs[7]  = mk(17'h00000, 17'h00000, 17'h00000, 17'h00000, 17'h00000, 17'h00003, 17'h00000, 17'h00000, 17'h10001);
        vecs[8]  = mk(17'h00000, 17'h00000, 17'h00000, 17'h00000, 17'h00000, 17'h10003, 17'h00000, 17'h00000, 17'h00001);
        vecs[9]  = mk(17'h00000, 17'h00000, 17'h1B300, 17'h00000, 17'h00000, 17'h00300, 17'h00000, 17'h00000, 17'h0B3AA);
        vecs[10] = mk(17'h00000, 17'h00000, 17'h0B400, 17'h00000, 17'h00000, 17'h00000, 17'h00000, 17'h00000, 17'h0B400);
        vecs[11] = mk(17'h00000, 17'h00000, 17'h1B400, 17'h00000, 17'h00000, 17'h00000, 17'h00000, 17'h00000, 17'h0B400);
        vecs[12] = mk(17'h00180, 17'h10280, 17'h00000, 17'h10100, 17'h00200, 17'h00000, 17'h00184, 17'h1027E, 17'h00000);

        // Reset state.
        do_reset();
        chk("rst_x", ox, 17'h0);
        chk("rst_y", oy, 17'h0);
        chk("rst_z", oz, 17'h0);
        chk("rst_valid", valid, 1'b0);
        chk("rst_done", done, 1'b0);
        nv = 0;
        for (int k = 0; k < 2 * TD; k++) begin
            step();
            if (valid) nv++;
        end
        chk("idle_no_valid", nv, 0);

        // Single-tick vectors from a fresh pose.
        for (int i = 0; i < 13; i++) begin
            do_reset();
            tx = vecs[i].tx; ty = vecs[i].ty; tz = vecs[i].tz;
            vx = vecs[i].vx; vy = vecs[i].vy; wz = vecs[i].wz;
            goal_n = 1'b1;
            pulse_load();
            wait_valid(seen);
            chk($sformatf("v%0d_valid_seen", i), seen, 1'b1);
            if (seen) begin
                chk($sformatf("v%0d_latency", i), cyc - last_tick, 2);
                chk($sformatf("v%0d_x", i), ox, vecs[i].ex);
                chk($sformatf("v%0d_y", i), oy, vecs[i].ey);
                chk($sformatf("v%0d_z", i), oz, vecs[i].ez);
                step();
                chk($sformatf("v%0d_valid_width", i), valid, 1'b0);
            end
        end

        // Goal detection with a restart, hold in DONE, then resume on reload.
        do_reset();
        tx = 17'h0; ty = 17'h00A00; tz = 17'h0;
        vx = 17'h03200; vy = 17'h0; wz = 17'h0;
        goal_n = 1'b1;
        pulse_load();
        wait_valid(seen);
        chk("goal_t1_y", oy, 17'h0099C);
        goal_n = 1'b0;
        to_tick();
        step();
        chk("goal_t2_done", done, 1'b0);
        step();
        chk("goal_t2_valid", valid, 1'b1);
        chk("goal_t2_y", oy, 17'h00938);
        goal_n = 1'b1;
        to_tick();
        step();
        goal_n = 1'b0;
        to_tick();
        step();
        chk("goal_restart_done", done, 1'b0);
        to_tick();
        step();
        chk("goal_done_set", done, 1'b1);
        step();
        step();
        step();
        nv = 0;
        for (int k = 0; k < 3 * TD; k++) begin
            step();
            if (valid) nv++;
        end
        chk("done_no_valid", nv, 0);
        chk("done_hold_y", oy, 17'h0080C);
        chk("done_hold_x", ox, 17'h0);
        chk("done_still", done, 1'b1);
        goal_n = 1'b1;
        pulse_load();
        chk("reload_done_clr", done, 1'b0);
        wait_valid(seen);
        chk("reload_valid_seen", seen, 1'b1);
        chk("reload_y", oy, 17'h007A8);

        // Reset coincident with load and tick while tracking.
        do_reset();
        tx = 17'h0; ty = 17'h00A00; tz = 17'h0;
        vx = 17'h03200; vy = 17'h0; wz = 17'h0;
        goal_n = 1'b1;
        pulse_load();
        wait_valid(seen);
        to_tick();
        rst = 1'b1;
        load = 1'b1;
        ty = 17'h05000;
        step();
        rst = 1'b0;
        load = 1'b0;
        chk("midrst_x", ox, 17'h0);
        chk("midrst_y", oy, 17'h0);
        chk("midrst_z", oz, 17'h0);
        chk("midrst_valid", valid, 1'b0);
        chk("midrst_done", done, 1'b0);
        nv = 0;
        for (int k = 0; k < 3 * TD; k++) begin
            step();
            if (valid) nv++;
        end
        chk("midrst_idle_no_valid", nv, 0);
        chk("midrst_hold_y", oy, 17'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
